// File: rtl/cosine_th2.sv
// rtl/cosine_th2.sv - cos(theta2) via law of cosines on sequenced double multiply/add cores
module cosine_th2 #(
    parameter logic [63:0] L_SUM_SQ  = 64'h4000000000000000,
    parameter logic [63:0] INV_2L1L2 = 64'h3FE0000000000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [63:0] X,
    input  logic [63:0] Y,
    output logic [63:0] CosTh2,
    output logic        dataReady,
    output logic        outOfReach,
    output logic        busy
);
    typedef enum logic [2:0] {
        S_IDLE, S_SQUARE, S_SUM, S_OFFSET, S_SCALE, S_CLAMP, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] x_q, y_q, xx_q, yy_q, acc_q, raw_q, clamp_q;
    logic        xx_done_q, yy_done_q, oor_pend_q;
    logic [63:0] cos_q;
    logic        ready_q, oor_q, busy_q;

    logic [63:0] mul_a_op_a, mul_a_op_b, mul_a_res, mul_b_res;
    logic [63:0] add_op_a, add_op_b, add_res;
    logic        mul_a_in, mul_a_rst, mul_a_dr;
    logic        mul_b_in, mul_b_rst, mul_b_dr;
    logic        add_in, add_rst, add_dr;
    logic [63:0] clamp_d;
    logic        clamp_oor_d;

    // X*X in Square, offset*INV_2L1L2 in Scale
    double_multiply u_mul_a (
        .clk(clk), .reset(mul_a_rst), .in_ready(mul_a_in),
        .a(mul_a_op_a), .b(mul_a_op_b), .result(mul_a_res), .data_ready(mul_a_dr)
    );
    // Y*Y in Square
    double_multiply u_mul_b (
        .clk(clk), .reset(mul_b_rst), .in_ready(mul_b_in),
        .a(y_q), .b(y_q), .result(mul_b_res), .data_ready(mul_b_dr)
    );
    // X²+Y² in Sum, sum-L_SUM_SQ in Offset
    double_adder u_add (
        .clk(clk), .reset(add_rst), .in_ready(add_in),
        .a(add_op_a), .b(add_op_b), .result(add_res), .data_ready(add_dr)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state: each arithmetic stage advances on its core's data_ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (enable) state_d = S_SQUARE;
            S_SQUARE: if ((xx_done_q || mul_a_dr) && (yy_done_q || mul_b_dr)) state_d = S_SUM;
            S_SUM:    if (add_dr) state_d = S_OFFSET;
            S_OFFSET: if (add_dr) state_d = S_SCALE;
            S_SCALE:  if (mul_a_dr) state_d = S_CLAMP;
            S_CLAMP:  state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Core operands, in_ready held until done, core reset pulsed on the consuming cycle
    always_comb begin
        mul_a_op_a = (state_q == S_SCALE) ? acc_q : x_q;
        mul_a_op_b = (state_q == S_SCALE) ? INV_2L1L2 : x_q;
        add_op_a   = (state_q == S_OFFSET) ? acc_q : xx_q;
        add_op_b   = (state_q == S_OFFSET) ? {~L_SUM_SQ[63], L_SUM_SQ[62:0]} : yy_q;
        mul_a_in   = !reset && !mul_a_dr &&
                     ((state_q == S_SQUARE && !xx_done_q) || state_q == S_SCALE);
        mul_b_in   = !reset && !mul_b_dr && state_q == S_SQUARE && !yy_done_q;
        add_in     = !reset && !add_dr && (state_q == S_SUM || state_q == S_OFFSET);
        mul_a_rst  = reset || (mul_a_dr && (state_q == S_SQUARE || state_q == S_SCALE));
        mul_b_rst  = reset || (mul_b_dr && state_q == S_SQUARE);
        add_rst    = reset || (add_dr && (state_q == S_SUM || state_q == S_OFFSET));
    end

    // Clamp raw result into [-1, +1]; NaN becomes canonical quiet NaN
    always_comb begin
        clamp_d     = raw_q;
        clamp_oor_d = 1'b0;
        if (raw_q[62:52] == 11'h7FF && raw_q[51:0] != 52'h0) begin
            clamp_d     = 64'h7FF8000000000000;
            clamp_oor_d = 1'b1;
        end else if (raw_q[62:0] > 63'h3FF0000000000000) begin
            clamp_d     = {raw_q[63], 63'h3FF0000000000000};
            clamp_oor_d = 1'b1;
        end
    end

    // Datapath capture and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0; y_q <= '0; xx_q <= '0; yy_q <= '0;
            acc_q <= '0; raw_q <= '0; clamp_q <= '0;
            xx_done_q <= 1'b0; yy_done_q <= 1'b0; oor_pend_q <= 1'b0;
            cos_q <= '0; ready_q <= 1'b0; oor_q <= 1'b0; busy_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (enable) begin
                    x_q <= X; y_q <= Y;
                    busy_q <= 1'b1; ready_q <= 1'b0; oor_q <= 1'b0;
                    xx_done_q <= 1'b0; yy_done_q <= 1'b0;
                end
                S_SQUARE: begin
                    if (mul_a_dr) begin xx_q <= mul_a_res; xx_done_q <= 1'b1; end
                    if (mul_b_dr) begin yy_q <= mul_b_res; yy_done_q <= 1'b1; end
                end
                S_SUM, S_OFFSET: if (add_dr) acc_q <= add_res;
                S_SCALE: if (mul_a_dr) raw_q <= mul_a_res;
                S_CLAMP: begin clamp_q <= clamp_d; oor_pend_q <= clamp_oor_d; end
                S_DONE: begin
                    cos_q <= clamp_q; oor_q <= oor_pend_q;
                    ready_q <= 1'b1; busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign CosTh2     = cos_q;
    assign dataReady  = ready_q;
    assign outOfReach = oor_q;
    assign busy       = busy_q;
endmodule

// Double multiply core: captures operands on in_ready, result 1 cycle later, held until reset
module double_multiply (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] result,
    output logic        data_ready
);
    logic [63:0] a_q, b_q, res_q;
    logic        run_q, dr_q;

    // Round-to-nearest-even multiply; subnormals flush to zero
    function automatic logic [63:0] fmul(input logic [63:0] x, input logic [63:0] y);
        logic         s;
        logic [105:0] p;
        logic [52:0]  m;
        logic         g, st;
        int           e;
        s = x[63] ^ y[63];
        if ((x[62:52] == 11'h7FF && x[51:0] != 0) || (y[62:52] == 11'h7FF && y[51:0] != 0))
            return 64'h7FF8000000000000;
        if (x[62:52] == 11'h7FF || y[62:52] == 11'h7FF) begin
            if (x[62:52] == 11'h0 || y[62:52] == 11'h0) return 64'h7FF8000000000000;
            return {s, 11'h7FF, 52'h0};
        end
        if (x[62:52] == 11'h0 || y[62:52] == 11'h0) return {s, 63'h0};
        p = {53'h0, 1'b1, x[51:0]} * {53'h0, 1'b1, y[51:0]};
        e = int'(x[62:52]) + int'(y[62:52]) - 1023;
        if (p[105]) begin
            m = {1'b0, p[104:53]}; g = p[52]; st = |p[51:0]; e = e + 1;
        end else begin
            m = {1'b0, p[103:52]}; g = p[51]; st = |p[50:0];
        end
        if (g && (st || m[0])) m = m + 53'd1;
        if (m[52]) e = e + 1;
        if (e >= 2047) return {s, 11'h7FF, 52'h0};
        if (e <= 0) return {s, 63'h0};
        return {s, e[10:0], m[51:0]};
    endfunction

    // Two-phase core sequence: capture, then compute
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0; b_q <= '0; res_q <= '0; run_q <= 1'b0; dr_q <= 1'b0;
        end else if (run_q) begin
            res_q <= fmul(a_q, b_q); dr_q <= 1'b1; run_q <= 1'b0;
        end else if (in_ready && !dr_q) begin
            a_q <= a; b_q <= b; run_q <= 1'b1;
        end
    end

    assign result     = res_q;
    assign data_ready = dr_q;
endmodule

// Double add core: same handshake and latency as the multiplier
module double_adder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic [63:0] result,
    output logic        data_ready
);
    logic [63:0] a_q, b_q, res_q;
    logic        run_q, dr_q;

    // Round-to-nearest-even add with guard/round/sticky; subnormals flush to zero
    function automatic logic [63:0] fadd(input logic [63:0] x, input logic [63:0] y);
        logic [63:0] bg, sm;
        logic [55:0] mb, ms, mask;
        logic [56:0] sum;
        logic [52:0] m;
        logic [10:0] d;
        logic        found;
        int          e, lz;
        if ((x[62:52] == 11'h7FF && x[51:0] != 0) || (y[62:52] == 11'h7FF && y[51:0] != 0))
            return 64'h7FF8000000000000;
        if (x[62:52] == 11'h7FF && y[62:52] == 11'h7FF && x[63] != y[63])
            return 64'h7FF8000000000000;
        if (x[62:52] == 11'h7FF) return x;
        if (y[62:52] == 11'h7FF) return y;
        if (x[62:52] == 11'h0 && y[62:52] == 11'h0) return {x[63] & y[63], 63'h0};
        if (x[62:52] == 11'h0) return y;
        if (y[62:52] == 11'h0) return x;
        if (x[62:0] >= y[62:0]) begin bg = x; sm = y; end
        else begin bg = y; sm = x; end
        mb = {1'b1, bg[51:0], 3'b000};
        ms = {1'b1, sm[51:0], 3'b000};
        d  = bg[62:52] - sm[62:52];
        if (d >= 11'd56) ms = 56'h1;
        else begin
            mask = ~({56{1'b1}} << d);
            ms   = (ms >> d) | {55'h0, |(ms & mask)};
        end
        if (bg[63] == sm[63]) sum = {1'b0, mb} + {1'b0, ms};
        else                  sum = {1'b0, mb} - {1'b0, ms};
        if (sum == 57'h0) return 64'h0;
        e = int'(bg[62:52]);
        if (sum[56]) begin
            sum = {1'b0, sum[56:1]} | {56'h0, sum[0]};
            e = e + 1;
        end else begin
            lz = 0; found = 1'b0;
            for (int i = 55; i >= 0; i--) begin
                if (!found) begin
                    if (sum[i]) found = 1'b1;
                    else        lz = lz + 1;
                end
            end
            sum = sum << lz;
            e = e - lz;
        end
        m = {1'b0, sum[54:3]};
        if (sum[2] && (sum[1] || sum[0] || m[0])) m = m + 53'd1;
        if (m[52]) e = e + 1;
        if (e >= 2047) return {bg[63], 11'h7FF, 52'h0};
        if (e <= 0) return {bg[63], 63'h0};
        return {bg[63], e[10:0], m[51:0]};
    endfunction

    // Two-phase core sequence: capture, then compute
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= '0; b_q <= '0; res_q <= '0; run_q <= 1'b0; dr_q <= 1'b0;
        end else if (run_q) begin
            res_q <= fadd(a_q, b_q); dr_q <= 1'b1; run_q <= 1'b0;
        end else if (in_ready && !dr_q) begin
            a_q <= a; b_q <= b; run_q <= 1'b1;
        end
    end

    assign result     = res_q;
    assign data_ready = dr_q;
endmodule

// File: tb/tb_cosine_th2.sv
// tb/tb_cosine_th2.sv - directed self-checking bench for cosine_th2
module tb_cosine_th2;
    localparam int LAT = 14;
    localparam logic [63:0] D_ZERO = 64'h0000000000000000;
    localparam logic [63:0] D_ONE  = 64'h3FF0000000000000;
    localparam logic [63:0] D_MONE = 64'hBFF0000000000000;
    localparam logic [63:0] D_TWO  = 64'h4000000000000000;
    localparam logic [63:0] D_THR  = 64'h4008000000000000;
    localparam logic [63:0] D_NAN  = 64'h7FF8000000000000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [63:0] X = '0;
    logic [63:0] Y = '0;
    logic [63:0] CosTh2;
    logic        dataReady, outOfReach, busy;

    int checks = 0;
    int errors = 0;
    int rise_cnt = 0;

    cosine_th2 dut (
        .clk(clk), .reset(reset), .enable(enable), .X(X), .Y(Y),
        .CosTh2(CosTh2), .dataReady(dataReady), .outOfReach(outOfReach), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge dataReady) rise_cnt++;

    task automatic start_op(input logic [63:0] x, input logic [63:0] y);
        @(negedge clk);
        enable = 1'b1; X = x; Y = y;
        @(posedge clk);
        #1 enable = 1'b0;
    endtask

    task automatic wait_ready(output int cyc);
        cyc = 0;
        while (!dataReady && cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic check_result(input string name, input int cyc, input logic [63:0] exp_cos,
                                input logic exp_oor);
        checks++;
        if (cyc !== LAT) begin
            errors++; $display("FAIL %s latency: got %0d expected %0d", name, cyc, LAT);
        end
        checks++;
        if (CosTh2 !== exp_cos) begin
            errors++; $display("FAIL %s CosTh2: got %h expected %h", name, CosTh2, exp_cos);
        end
        checks++;
        if (outOfReach !== exp_oor) begin
            errors++; $display("FAIL %s outOfReach: got %b expected %b", name, outOfReach, exp_oor);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL %s busy_after: got %b expected 0", name, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({CosTh2, dataReady, outOfReach, busy} !== {D_ZERO, 3'b000}) begin
            errors++;
            $display("FAIL reset_state: got cos=%h rdy=%b oor=%b busy=%b expected all zero",
                     CosTh2, dataReady, outOfReach, busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_in_reach();
        int cyc;
        start_op(D_TWO, D_ZERO);
        checks++;
        if (busy !== 1'b1 || dataReady !== 1'b0) begin
            errors++; $display("FAIL start_flags: got busy=%b rdy=%b expected busy=1 rdy=0", busy, dataReady);
        end
        wait_ready(cyc);
        check_result("x2_y0", cyc, D_ONE, 1'b0);
    endtask

    task automatic test_zero_and_minus_one();
        int cyc;
        start_op(D_ONE, D_ONE);
        wait_ready(cyc);
        check_result("x1_y1", cyc, D_ZERO, 1'b0);
        start_op(D_ZERO, D_ZERO);
        wait_ready(cyc);
        check_result("x0_y0", cyc, D_MONE, 1'b0);
    endtask

    task automatic test_out_of_reach();
        int cyc;
        start_op(D_THR, D_ZERO);
        wait_ready(cyc);
        check_result("x3_y0", cyc, D_ONE, 1'b1);
    endtask

    task automatic test_ignored_enable();
        int cyc, r0;
        r0 = rise_cnt;
        start_op(D_TWO, D_ZERO);
        repeat (5) @(posedge clk);
        #1 enable = 1'b1; X = D_THR; Y = D_ONE;
        @(posedge clk);
        #1 enable = 1'b0;
        cyc = 6;
        while (!dataReady && cyc < 100) begin
            @(posedge clk);
            #1 cyc++;
        end
        check_result("ignored_en", cyc, D_ONE, 1'b0);
        repeat (LAT + 4) @(posedge clk);
        #1;
        checks++;
        if (rise_cnt - r0 !== 1) begin
            errors++; $display("FAIL ignored_en rises: got %0d expected 1", rise_cnt - r0);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        start_op(D_THR, D_ZERO);
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if ({CosTh2, dataReady, busy} !== {D_ZERO, 2'b00}) begin
            errors++;
            $display("FAIL reset_mid: got cos=%h rdy=%b busy=%b expected 0/0/0", CosTh2, dataReady, busy);
        end
        start_op(D_ONE, D_ONE);
        wait_ready(cyc);
        check_result("after_reset", cyc, D_ZERO, 1'b0);
    endtask

    task automatic test_nan_back_to_back();
        int cyc;
        start_op(D_NAN, D_ZERO);
        wait_ready(cyc);
        check_result("nan", cyc, D_NAN, 1'b1);
        start_op(D_TWO, D_ZERO);
        checks++;
        if (dataReady !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b_drop: got rdy=%b busy=%b expected rdy=0 busy=1", dataReady, busy);
        end
        wait_ready(cyc);
        check_result("b2b", cyc, D_ONE, 1'b0);
    endtask

    initial begin
        test_reset();
        test_in_reach();
        test_zero_and_minus_one();
        test_out_of_reach();
        test_ignored_enable();
        test_reset_mid();
        test_nan_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cosine_th2.md
Name: cosine_th2

Overview:
- Computes cos(theta2) for the SCARA inverse-kinematics chain from the target end-effector position (X, Y), using the law of cosines.
- Formula: CosTh2 = (X² + Y² − (L1² + L2²)) · 1/(2·L1·L2).
- Sits directly upstream of the sine-of-theta2 stage; its CosTh2/dataReady pair feeds that stage's CosTh2/enable inputs.
- All arithmetic is IEEE-754 double, sequenced through the existing DoubleMultiply and DoubleAdder cores. It clamps unreachable targets so the downstream square root never sees a negative operand.

Parameters:
- L_SUM_SQ, 64'h4000000000000000, double bit pattern of L1²+L2² (default 2.0, i.e. L1=L2=1.0).
- INV_2L1L2, 64'h3FE0000000000000, double bit pattern of 1/(2·L1·L2) (default 0.5).

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- reset, input, 1, synchronous, active-high.
- enable, input, 1, start request; sampled only in Idle.
- X, input, 64, target x, IEEE double.
- Y, input, 64, target y, IEEE double.
- CosTh2, output, 64, cos(theta2), IEEE double, clamped to [−1.0, +1.0].
- dataReady, output, 1, CosTh2 valid; held until next accepted start or reset.
- outOfReach, output, 1, target outside the workspace annulus; valid while dataReady=1.
- busy, output, 1, high from accepted start until dataReady rises.

Behaviour:
- Reset (synchronous, active-high):
  - state=Idle; CosTh2=0, dataReady=0, outOfReach=0, busy=0.
  - All core enables are 0 and all core resets are asserted.
  - Reset mid-operation abandons the computation with no output; the next start behaves as from power-up.
- Start:
  - In Idle, enable=1 captures X and Y into internal registers and sets busy=1.
  - The same edge clears dataReady and outOfReach and moves to Square.
  - enable while busy is ignored. X and Y may change freely after capture.
- Core handshake, identical for every stage:
  - Hold the core's in_ready=1 with its operands until data_ready=1.
  - On that cycle, register the result, drop in_ready, and pulse the core reset high for 1 cycle.
  - Then advance. Each stage costs its core latency + 1 cycle.
- States:
  - Idle: wait for enable.
  - Square: two DoubleMultiply instances compute X·X and Y·Y in parallel. Advance only when both have signalled done; each result is latched independently when its done arrives.
  - Sum: DoubleAdder computes X²+Y².
  - Offset: DoubleAdder computes sum + (−L_SUM_SQ), negation by sign-bit flip.
  - Scale: DoubleMultiply computes offset·INV_2L1L2 into a raw register.
  - Clamp: 1 cycle, pure bit logic.
  - Done: drive CosTh2, set dataReady=1, clear busy, return to Idle in the same cycle.
- Clamp rules, operating on raw:
  - NaN (exp=7FF, mantissa≠0): CosTh2=64'h7FF8000000000000, outOfReach=1.
  - raw[62:0] > 63'h3FF0000000000000 (magnitude > 1.0, including ±Inf): CosTh2={raw[63], 63'h3FF0000000000000}, outOfReach=1.
  - Otherwise: CosTh2=raw, outOfReach=0. Exactly ±1.0 is in reach.
- −0.0 passes through unchanged.
- Latency: 2·T_mul + 2·T_add + 4 stage-capture cycles + 1 Clamp cycle + 1 start cycle, counted from the enable edge to the dataReady rise. The bench measures and asserts this constant.
- Back-to-back operation:
  - enable may be reasserted in the first Idle cycle after dataReady rises.
  - That start clears dataReady on the same edge, so the downstream stage sees a fresh rising edge per result.
- Parameters are constants; no runtime link-length change.

Test Plan:
- L1=L2=1 defaults; X=2.0 (4000000000000000), Y=0 -> CosTh2=3FF0000000000000 (+1.0), outOfReach=0, dataReady rises at the measured latency, busy low afterwards.
- X=1.0, Y=1.0 -> CosTh2=0000000000000000, outOfReach=0. X=0, Y=0 -> CosTh2=BFF0000000000000 (−1.0), outOfReach=0.
- X=3.0 (4008000000000000), Y=0 -> raw=3.5; CosTh2=3FF0000000000000, outOfReach=1.
- enable pulsed 5 cycles after a start, with X and Y changed to different values -> ignored; the result matches the original capture and only one dataReady rise occurs.
- reset asserted during Offset -> next cycle dataReady=0, busy=0, CosTh2=0. A fresh start with X=1.0, Y=1.0 then yields 0.0 at exactly the nominal latency.
- X=7FF8000000000000 (NaN) -> CosTh2=7FF8000000000000, outOfReach=1. A back-to-back start with X=2.0 in the first Idle cycle -> dataReady drops, then rises with +1.0.
